bsa_scheduler: RTL and testbench
================================

# bsa_scheduler

Controller that shares one bit-serial adder datapath between two requesters. It arbitrates round-robin, loads the winner's operands LSB-first into the serial core, and sequences exactly WIDTH shift/add cycles. It then returns the sum and carry-out with a one-cycle done/ack pulse to the granted requester. It sits between the operand producers and the serial arithmetic path and is the only block that drives the core's load, shift and clear controls.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; also the number of serial add cycles per operation
- CNTW, $clog2(WIDTH+1), bit-counter width (derived; do not override)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- res  in  1  reset; asynchronous, active-high
- req0  in  1  requester 0 request; level, held until ack0
- a0, b0  in  WIDTH  requester 0 operands; sampled only at grant
- req1  in  1  requester 1 request; level, held until ack1
- a1, b1  in  WIDTH  requester 1 operands; sampled only at grant
- busy  out  1  high from grant edge until return to IDLE
- gnt_id  out  1  requester currently or last served
- done  out  1  one-cycle pulse; sum/cout valid
- ack0, ack1  out  1  one-cycle pulse to the served requester, coincident with done
- sum  out  WIDTH  result (a+b) mod 2^WIDTH; held until next done
- cout  out  1  carry out of bit WIDTH-1; held with sum

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: if req0|req1 at an edge, grant per round-robin. Latch the winner's a/b into core shift registers, clear carry and partial sum, set cnt=0, set gnt_id, and go to SHIFT. With no request, remain in IDLE.
- Round-robin: pointer last_id; on simultaneous requests grant ~last_id. A single request always wins. last_id resets to 1, so req0 wins the first tie.
- SHIFT: on each edge the core adds the current LSBs plus carry, shifts the sum bit in at MSB, shifts operands right, and registers carry; cnt increments. When cnt reaches WIDTH-1 at an edge, perform the final add and go to DONE.
- DONE: done=1 and ack[gnt_id]=1 for this cycle; sum/cout registers are loaded on the entry edge. Next edge: last_id<=gnt_id, go to IDLE.
- Operands are captured at grant only. Changes to a/b or deassertion of req during SHIFT are ignored; the operation completes and is acked regardless.
- A requester that keeps req high after ack is treated as a new request in IDLE. Fairness guarantees that the other pending requester is served first.
- Undriven (X) serial bits never reach state; the core forces X sum/carry bits to 0.

## Timing
- Reset values: busy=0, done=0, ack0=ack1=0, gnt_id=0, sum=0, cout=0, cnt=0, carry=0, last_id=1, state=IDLE.
- Reset asserted mid-operation aborts immediately (asynchronously). No done or ack is issued for the aborted operation.
- Latency: req high at edge E (grant) -> done high during the cycle after edge E+WIDTH, i.e. WIDTH+1 cycles after the grant edge (9 for WIDTH=8).
- Back-to-back service: next grant earliest at the edge after DONE. Period is WIDTH+2 cycles per operation.
- busy rises at the grant edge and falls at the DONE->IDLE edge. busy=1 throughout DONE.
- Width rule: sum is WIDTH bits, cout is the extra bit; e.g. 8'hFF+8'h01 -> sum 8'h00, cout 1.

## Structure
- Shared package bsa_pkg: state enum (IDLE, SHIFT, DONE), default WIDTH constant.
- Sub-module serial_add_core: two right-shift operand registers with load, full adder, carry FF, and sum shift register with clear. Interface is clk, res, load, shift, a, b, sum, cout.
- The top holds the FSM, bit counter, round-robin pointer, result registers and ack decode.

## Test plan
- Single op: req0, a0=8'h35, b0=8'h4A -> done after 9 cycles, sum=8'h7F, cout=0, ack0 only, gnt_id=0.
- Overflow: req1, a1=8'hFF, b1=8'h01 -> sum=8'h00, cout=1, ack1.
- Tie and fairness: req0 and req1 both held from reset with a0=3,b0=4 and a1=10,b1=20. Required: first done sum=7 (gnt 0), second done sum=30 (gnt 1) exactly 10 cycles later, third service goes to gnt 0.
- Operand change mid-op: a0=8'h10, b0=8'h20 granted, then a0/b0 changed to 8'hFF during SHIFT -> sum=8'h30.
- Reset mid-op: assert res at SHIFT cycle 4 -> all outputs 0 immediately and no ack. After release, a pending req0 is served normally.
- Idle hold: no requests for 20 cycles -> busy=0, done=0, sum holds its previous value.

Source files
------------

// File: rtl/bsa_pkg.sv
// Shared types and defaults for the bit-serial adder scheduler.
package bsa_pkg;

   localparam int BSA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bsa_state_e;

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial adder: operands shift out LSB-first, sum bits shift in at the MSB.
// sum/cout present the result as it will stand once the current shift is
// registered, so the owner can capture the finished word on the final shift edge.
module serial_add_core
   import bsa_pkg::*;
#(
   parameter int WIDTH = BSA_WIDTH
) (
   input  logic             clk,
   input  logic             res,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             carry_q;
   logic             fa_s;
   logic             fa_c;
   logic             bit_s;
   logic             bit_c;

   // Full adder on the current LSBs; unknown bits are squashed to 0 before they reach state.
   always_comb begin
      fa_s  = a_q[0] ^ b_q[0] ^ carry_q;
      fa_c  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      bit_s = (fa_s === 1'b1);
      bit_c = (fa_c === 1'b1);
      sum_d = {bit_s, sum_q[WIDTH-1:1]};
   end

   assign sum  = sum_d;
   assign cout = bit_c;

   // Operand/sum shift registers and carry flop; load takes priority over shift.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else if (load) begin
         a_q     <= a;
         b_q     <= b;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else if (shift) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         sum_q   <= sum_d;
         carry_q <= bit_c;
      end
   end

endmodule

// File: rtl/bsa_scheduler.sv
// Round-robin scheduler sharing one serial adder between two requesters.
// state | meaning
// IDLE  | waiting for req0/req1; grant and operand load happen on the leaving edge
// SHIFT | WIDTH serial add cycles, cnt counts completed shifts
// DONE  | result valid, done and ack to the served requester for one cycle
module bsa_scheduler
   import bsa_pkg::*;
#(
   parameter int WIDTH = BSA_WIDTH,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             busy,
   output logic             gnt_id,
   output logic             done,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   bsa_state_e       state_q;
   bsa_state_e       state_d;
   logic [CNTW-1:0]  cnt_q;
   logic             last_id_q;
   logic             gnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             any_req;
   logic             win_id;
   logic             last_shift;
   logic             core_load;
   logic             core_shift;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_sum;
   logic             core_cout;

   // Arbitration: a lone request wins outright, a tie goes to the one not served last.
   always_comb begin
      any_req = req0 | req1;
      if (req0 && req1) begin
         win_id = ~last_id_q;
      end else begin
         win_id = req1;
      end
      core_a     = win_id ? a1 : a0;
      core_b     = win_id ? b1 : b0;
      last_shift = (cnt_q == CNTW'(WIDTH - 1));
      core_load  = (state_q == IDLE) && any_req;
      core_shift = (state_q == SHIFT);
   end

   // State register.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = SHIFT;
         SHIFT:   if (last_shift) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the registered state and grant.
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
      ack0 = done & ~gnt_q;
      ack1 = done &  gnt_q;
   end

   // Bit counter, grant/pointer bookkeeping and result capture on the final shift.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt_q     <= '0;
         gnt_q     <= 1'b0;
         last_id_q <= 1'b1;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         if (core_load) begin
            cnt_q <= '0;
            gnt_q <= win_id;
         end else if (core_shift) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (core_shift && last_shift) begin
            sum_q  <= core_sum;
            cout_q <= core_cout;
         end
         if (state_q == DONE) begin
            last_id_q <= gnt_q;
         end
      end
   end

   assign gnt_id = gnt_q;
   assign sum    = sum_q;
   assign cout   = cout_q;

   serial_add_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk   (clk),
      .res   (res),
      .load  (core_load),
      .shift (core_shift),
      .a     (core_a),
      .b     (core_b),
      .sum   (core_sum),
      .cout  (core_cout)
   );

endmodule

// File: tb/tb_bsa_scheduler.sv
// Directed bench for bsa_scheduler with hand-computed results.
module tb_bsa_scheduler;

   logic       clk;
   logic       res;
   logic       req0;
   logic [7:0] a0;
   logic [7:0] b0;
   logic       req1;
   logic [7:0] a1;
   logic [7:0] b1;
   logic       busy;
   logic       gnt_id;
   logic       done;
   logic       ack0;
   logic       ack1;
   logic [7:0] sum;
   logic       cout;

   int total;
   int bad;

   bsa_scheduler #(.WIDTH(8)) dut (
      .clk    (clk),
      .res    (res),
      .req0   (req0),
      .a0     (a0),
      .b0     (b0),
      .req1   (req1),
      .a1     (a1),
      .b1     (b1),
      .busy   (busy),
      .gnt_id (gnt_id),
      .done   (done),
      .ack0   (ack0),
      .ack1   (ack1),
      .sum    (sum),
      .cout   (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Counts rising edges until done is seen on a falling edge; bounded.
   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (done) break;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
   endtask

   int  cyc;
   logic seen;

   initial begin
      total = 0;
      bad   = 0;
      res   = 1'b1;
      req0  = 1'b1;
      req1  = 1'b1;
      a0    = 8'd3;
      b0    = 8'd4;
      a1    = 8'd10;
      b1    = 8'd20;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ack",  {30'd0, ack1, ack0}, 32'd0);
      chk("rst_gnt",  {31'd0, gnt_id}, 32'd0);
      chk("rst_sum",  {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);

      // Tie and fairness: both held from reset
      res = 1'b0;
      wait_done(cyc);
      chk("tie1_lat",  cyc, 32'd9);
      chk("tie1_gnt",  {31'd0, gnt_id}, 32'd0);
      chk("tie1_sum",  {24'd0, sum}, 32'd7);
      chk("tie1_ack",  {30'd0, ack1, ack0}, 32'b01);
      chk("tie1_busy", {31'd0, busy}, 32'd1);
      wait_done(cyc);
      chk("tie2_per",  cyc, 32'd10);
      chk("tie2_gnt",  {31'd0, gnt_id}, 32'd1);
      chk("tie2_sum",  {24'd0, sum}, 32'd30);
      chk("tie2_ack",  {30'd0, ack1, ack0}, 32'b10);
      wait_done(cyc);
      chk("tie3_per",  cyc, 32'd10);
      chk("tie3_gnt",  {31'd0, gnt_id}, 32'd0);
      chk("tie3_sum",  {24'd0, sum}, 32'd7);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      chk("tie_idle_busy", {31'd0, busy}, 32'd0);
      chk("tie_idle_done", {31'd0, done}, 32'd0);
      @(negedge clk);

      // Single op on requester 0
      a0   = 8'h35;
      b0   = 8'h4A;
      req0 = 1'b1;
      wait_done(cyc);
      req0 = 1'b0;
      chk("one_lat",  cyc, 32'd9);
      chk("one_sum",  {24'd0, sum}, 32'h7F);
      chk("one_cout", {31'd0, cout}, 32'd0);
      chk("one_ack",  {30'd0, ack1, ack0}, 32'b01);
      chk("one_gnt",  {31'd0, gnt_id}, 32'd0);
      @(negedge clk);
      chk("one_after_busy", {31'd0, busy}, 32'd0);
      chk("one_after_sum",  {24'd0, sum}, 32'h7F);

      // Overflow on requester 1
      a1   = 8'hFF;
      b1   = 8'h01;
      req1 = 1'b1;
      wait_done(cyc);
      req1 = 1'b0;
      chk("ovf_sum",  {24'd0, sum}, 32'h00);
      chk("ovf_cout", {31'd0, cout}, 32'd1);
      chk("ovf_ack",  {30'd0, ack1, ack0}, 32'b10);
      chk("ovf_gnt",  {31'd0, gnt_id}, 32'd1);
      @(negedge clk);

      // Operands and request change while shifting
      a0   = 8'h10;
      b0   = 8'h20;
      req0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      a0   = 8'hFF;
      b0   = 8'hFF;
      req0 = 1'b0;
      wait_done(cyc);
      chk("chg_sum",  {24'd0, sum}, 32'h30);
      chk("chg_cout", {31'd0, cout}, 32'd0);
      chk("chg_ack",  {30'd0, ack1, ack0}, 32'b01);
      @(negedge clk);

      // Reset in the middle of an operation, then normal service of a pending req0
      a0   = 8'h01;
      b0   = 8'h02;
      req0 = 1'b1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #2 res = 1'b1;
      #1;
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_done", {31'd0, done}, 32'd0);
      chk("mid_sum",  {24'd0, sum}, 32'd0);
      chk("mid_cout", {31'd0, cout}, 32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | ack0 | ack1 | done;
      end
      chk("mid_noack", {31'd0, seen}, 32'd0);
      res = 1'b0;
      wait_done(cyc);
      req0 = 1'b0;
      chk("post_lat", cyc, 32'd9);
      chk("post_sum", {24'd0, sum}, 32'd3);
      chk("post_ack", {30'd0, ack1, ack0}, 32'b01);

      // Idle hold
      @(negedge clk);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | busy | done;
      end
      chk("idle_act", {31'd0, seen}, 32'd0);
      chk("idle_sum", {24'd0, sum}, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
